// File: rtl/jt51_phrom_arb_if.sv
// Request/result bus between the phase-ROM requesters and jt51_phrom_arb.
// master = requester side, slave = arbiter side.
interface jt51_phrom_arb_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]    req;
  logic [10*N-1:0] phase;
  logic [N-1:0]    ack;
  logic            dout_valid;
  logic [IDW-1:0]  dout_id;
  logic            dout_sign;
  logic [11:0]     dout_logsin;

  modport master (
    output req, phase,
    input  ack, dout_valid, dout_id, dout_sign, dout_logsin
  );

  modport slave (
    input  req, phase,
    output ack, dout_valid, dout_id, dout_sign, dout_logsin
  );
endinterface

// File: rtl/jt51_phrom_arb.sv
// Round-robin arbiter/sequencer sharing one registered 256x12 log-sine ROM.
// Define JT51_PHROM_ARB_FOLD_EN for quarter-wave folding on phase[9:8].
module jt51_phrom_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen_i,
  jt51_phrom_arb_if.slave      bus,
  output logic [7:0]           rom_addr_o,
  output logic                 rom_cen_o,
  input  logic [11:0]          rom_ph_i
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   scan_idx;
  logic           req_hit;
  logic           accept;
  logic [7:0]     addr_d;
  logic           sign_d;

  logic           s1_valid_q, s2_valid_q;
  logic [IDW-1:0] s1_id_q, s2_id_q;
  logic           s1_sign_q, s2_sign_q;
  logic [7:0]     rom_addr_q;

  logic           dout_valid_q;
  logic [IDW-1:0] dout_id_q;
  logic           dout_sign_q;
  logic [11:0]    dout_logsin_q;

  // Scan requesters starting at ptr_q, wrapping at N; first hit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    req_hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(N)) scan_idx = scan_idx - (IDW+1)'(N);
      req_hit = |(bus.req & (N'(1) << scan_idx));
      if (!grant_vld && req_hit) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_id == IDW'(N-1)) ? '0 : grant_id + IDW'(1);
    end
  end

  assign accept  = cen_i & rst_n & grant_vld;
  assign bus.ack = accept ? (N'(1) << grant_id) : '0;

`ifdef JT51_PHROM_ARB_FOLD_EN
  logic [9:0] phase_sel;
  assign phase_sel = 10'(bus.phase >> (10 * grant_id));
  // Second quarter of each half-wave mirrors the first.
  assign addr_d    = phase_sel[8] ? ~phase_sel[7:0] : phase_sel[7:0];
  assign sign_d    = phase_sel[9];
`else
  assign addr_d    = 8'(bus.phase >> (10 * grant_id));
  assign sign_d    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_id_q       <= '0;
      s1_sign_q     <= 1'b0;
      rom_addr_q    <= '0;
      s2_valid_q    <= 1'b0;
      s2_id_q       <= '0;
      s2_sign_q     <= 1'b0;
      dout_valid_q  <= 1'b0;
      dout_id_q     <= '0;
      dout_sign_q   <= 1'b0;
      dout_logsin_q <= '0;
    end else if (cen_i) begin
      s1_valid_q <= accept;
      if (accept) begin
        ptr_q      <= ptr_d;
        s1_id_q    <= grant_id;
        s1_sign_q  <= sign_d;
        rom_addr_q <= addr_d;
      end
      // ROM samples rom_addr_q on this same edge; its data lines up with stage 2.
      s2_valid_q    <= s1_valid_q;
      s2_id_q       <= s1_id_q;
      s2_sign_q     <= s1_sign_q;
      dout_valid_q  <= s2_valid_q;
      dout_id_q     <= s2_id_q;
      dout_sign_q   <= s2_sign_q;
      dout_logsin_q <= rom_ph_i;
    end
  end

  assign rom_addr_o      = rom_addr_q;
  assign rom_cen_o       = cen_i;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.dout_id     = dout_id_q;
  assign bus.dout_sign   = dout_sign_q;
  assign bus.dout_logsin = dout_logsin_q;

endmodule

// File: tb/tb_jt51_phrom_arb.sv
// Bench for jt51_phrom_arb: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations. Honors JT51_PHROM_ARB_FOLD_EN.
module tb_jt51_phrom_arb;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic [7:0]  rom_addr;
  logic        rom_cen;
  logic [11:0] rom_ph = '0;
  logic [11:0] rom_tab [256];

  int checks = 0;
  int failures = 0;

  jt51_phrom_arb_if #(.N(N), .IDW(IDW)) bus ();

  jt51_phrom_arb #(.N(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen_i      (cen),
    .bus        (bus),
    .rom_addr_o (rom_addr),
    .rom_cen_o  (rom_cen),
    .rom_ph_i   (rom_ph)
  );

  always #5 clk = ~clk;

  // External registered ROM; addr 0 and 0xFF carry the real log-sine end values.
  initial begin
    for (int a = 0; a < 256; a++) rom_tab[a] = (a == 0) ? 12'h859 : 12'((255 - a) * 8);
  end
  always @(posedge clk) if (rom_cen) rom_ph <= rom_tab[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fold_addr(input logic [9:0] ph);
`ifdef JT51_PHROM_ARB_FOLD_EN
    return ph[8] ? ~ph[7:0] : ph[7:0];
`else
    return ph[7:0];
`endif
  endfunction

  function automatic bit fold_sign(input logic [9:0] ph);
`ifdef JT51_PHROM_ARB_FOLD_EN
    return ph[9];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference model: results are scheduled for the cen edge two after acceptance.
  typedef struct { int due; int id; bit sign; logic [11:0] ls; } res_t;
  res_t pend[$];
  int         m_ptr = 0;
  int         m_edge = 0;
  bit         m_valid = 0;
  int         m_id = 0;
  bit         m_sign = 0;
  logic [11:0] m_ls = '0;
  logic [7:0] m_addr = '0;

  initial begin
    int g;
    logic [9:0] ph;
    res_t r;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        m_ptr = 0; m_edge = 0; m_valid = 0; m_addr = '0;
      end else if (cen) begin
        m_edge++;
        m_valid = 0;
        if (pend.size() > 0 && pend[0].due == m_edge) begin
          r = pend.pop_front();
          m_valid = 1; m_id = r.id; m_sign = r.sign; m_ls = r.ls;
          $display("result id=%0d sign=%0d logsin=0x%03h t=%0t", m_id, m_sign, m_ls, $time);
        end
        g = pick(bus.req, m_ptr);
        if (g >= 0) begin
          ph = bus.phase[10*g +: 10];
          m_ptr = (g + 1) % N;
          m_addr = fold_addr(ph);
          r.due = m_edge + 2; r.id = g; r.sign = fold_sign(ph); r.ls = rom_tab[m_addr];
          pend.push_back(r);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    int g;
    logic [N-1:0] e_ack;
    forever begin
      @(negedge clk);
      g = pick(bus.req, m_ptr);
      e_ack = (rst_n && cen && g >= 0) ? N'(1 << g) : '0;
      chk("cmp_ack", 32'(bus.ack), 32'(e_ack));
      chk("cmp_rom_cen", 32'(rom_cen), 32'(cen));
      chk("cmp_rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("cmp_valid", 32'(bus.dout_valid), 32'(m_valid));
      if (m_valid) begin
        chk("cmp_id", 32'(bus.dout_id), 32'(m_id));
        chk("cmp_sign", 32'(bus.dout_sign), 32'(m_sign));
        chk("cmp_logsin", 32'(bus.dout_logsin), 32'(m_ls));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ph(input int i, input logic [9:0] v);
    bus.phase[10*i +: 10] = v;
  endtask

  task automatic single(input int id, input logic [9:0] ph, input logic [7:0] e_addr,
                        input bit e_sign, input logic [11:0] e_ls);
    bus.req = N'(1 << id);
    set_ph(id, ph);
    @(negedge clk); chk("single_ack", 32'(bus.ack), 32'(1 << id));
    tick(); bus.req = '0;
    @(negedge clk); chk("single_addr", 32'(rom_addr), 32'(e_addr));
    chk("single_ack_drop", 32'(bus.ack), 0);
    tick();
    @(negedge clk); chk("single_early", 32'(bus.dout_valid), 0);
    tick();
    @(negedge clk);
    chk("single_valid", 32'(bus.dout_valid), 1);
    chk("single_id", 32'(bus.dout_id), 32'(id));
    chk("single_sign", 32'(bus.dout_sign), 32'(e_sign));
    chk("single_logsin", 32'(bus.dout_logsin), 32'(e_ls));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '1;
    bus.phase = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_id", 32'(bus.dout_id), 0);
    chk("rst_sign", 32'(bus.dout_sign), 0);
    chk("rst_logsin", 32'(bus.dout_logsin), 0);
    tick();
    bus.req = '0;
    rst_n = 1'b1;
    tick();

`ifdef JT51_PHROM_ARB_FOLD_EN
    single(1, 10'h100, 8'hFF, 1'b0, 12'h000);
    single(2, 10'h000, 8'h00, 1'b0, 12'h859);
    single(3, 10'h3FF, 8'h00, 1'b1, 12'h859);
`else
    single(1, 10'h3FF, 8'hFF, 1'b0, 12'h000);
    single(2, 10'h000, 8'h00, 1'b0, 12'h859);
    single(3, 10'h2AB, 8'hAB, 1'b0, 12'h2A0);
`endif

    // Round robin with all four held high; ptr is back at 0 here.
    for (int i = 0; i < N; i++) set_ph(i, 10'(8'h10 + i));
    bus.req = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 5) chk("rr_ack", 32'(bus.ack), 32'(1 << (c % 4)));
      if (c >= 3) begin
        chk("rr_valid", 32'(bus.dout_valid), 1);
        chk("rr_id", 32'(bus.dout_id), 32'((c - 3) % 4));
      end
      tick();
      if (c == 4) bus.req = '0;
    end

    // cen gating: requester 2, phase 0x005.
    cen = 1'b0; bus.req = 4'b0100; set_ph(2, 10'h005);
    @(negedge clk); chk("gate_ack_off", 32'(bus.ack), 0);
    tick(); cen = 1'b1;
    @(negedge clk); chk("gate_ack_on", 32'(bus.ack), 32'h4);
    tick(); bus.req = '0; cen = 1'b0;
    @(negedge clk); chk("gate_addr", 32'(rom_addr), 32'h05);
    tick(); cen = 1'b1;
    tick(); cen = 1'b0;
    @(negedge clk); chk("gate_early", 32'(bus.dout_valid), 0);
    tick(); cen = 1'b1;
    tick(); cen = 1'b0;
    @(negedge clk);
    chk("gate_valid", 32'(bus.dout_valid), 1);
    chk("gate_id", 32'(bus.dout_id), 2);
    chk("gate_logsin", 32'(bus.dout_logsin), 32'h7D0);
    tick();
    @(negedge clk);
    chk("gate_hold_valid", 32'(bus.dout_valid), 1);
    chk("gate_hold_logsin", 32'(bus.dout_logsin), 32'h7D0);
    cen = 1'b1;
    tick();
    @(negedge clk); chk("gate_clear", 32'(bus.dout_valid), 0);

    // Mid-stream reset: one result showing, two in flight.
    tick();
    bus.req = '1;
    repeat (3) tick();
    chk("mid_pre_valid", 32'(bus.dout_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(bus.dout_valid), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk); chk("mid_first_grant", 32'(bus.ack), 32'h1);
    tick(); bus.req = '0;
    @(negedge clk); chk("mid_no_stale1", 32'(bus.dout_valid), 0);
    tick();
    @(negedge clk); chk("mid_no_stale2", 32'(bus.dout_valid), 0);
    tick();
    @(negedge clk);
    chk("mid_new_valid", 32'(bus.dout_valid), 1);
    chk("mid_new_id", 32'(bus.dout_id), 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jt51_phrom_arb.md
# jt51_phrom_arb

Round-robin arbiter and sequencer sharing one registered 256×12 log-sine phase ROM between N requesters (operator pipeline, LFO, test port). It accepts 10-bit phase requests over a req/ack handshake, folds them to a quarter-wave ROM address, drives the ROM port and returns the 12-bit log-sine value, sign and requester ID through a pipelined result port. It sits between the requesters and the single ROM instance.

## Interface
- N, 4, number of requesters (2..8)
- IDW, 2, requester-ID width; N ≤ 2^IDW
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cen  in  1  clock enable; all state advances only on clk edges with cen=1
- req  in  N  request per requester; held with its phase until accepted
- phase  in  10*N  phase of requester i in bits [10i+9:10i]
- ack  out  N  one-hot grant, combinational; transfer occurs on an edge where cen & req[i] & ack[i]
- rom_addr  out  8  ROM address, registered
- rom_cen  out  1  ROM read enable, equals cen
- rom_ph  in  12  ROM registered output, valid one cen edge after rom_addr
- dout_valid  out  1  result valid, registered
- dout_id  out  IDW  requester ID of result
- dout_sign  out  1  sign of result (1 = negative half-wave)
- dout_logsin  out  12  log-sine magnitude from ROM

## Operation
- Priority pointer ptr (IDW bits): the requester scanned first. Grant = first i with req[i]=1 in order ptr, ptr+1, …, N-1, 0, …, ptr-1.
- ack = 0 whenever cen=0, rst_n=0 or req=0. ack never has more than one bit set.
- On an accepting edge for requester g: ptr ← (g+1) mod N; stage-1 registers load valid=1, id=g, sign, rom_addr ← folded address.
- Edges with no accepted request load stage-1 valid=0; rom_addr holds its value.
- Stage 2: at the next cen edge, id/sign/valid move to stage 2 while the ROM captures rom_addr.
- Output: at the following cen edge, dout_logsin ← rom_ph, dout_id/dout_sign ← stage 2, dout_valid ← stage-2 valid.
- Pipeline is fully throughput-capable: one acceptance per cen edge, no stalls and no back-pressure on the result port.
- Folding (see Configuration): addr = phase[8] ? ~phase[7:0] : phase[7:0]; sign = phase[9].
- Requesters with req=0 never change ptr. ptr wraps from N-1 to 0.

## Timing
- Reset values: ptr=0, rom_addr=0, all stage valids=0, dout_valid=0, dout_id=0, dout_sign=0, dout_logsin=0. ack=0 while rst_n=0.
- Reset assertion mid-operation clears all valids immediately (asynchronous). In-flight results are discarded and never presented.
- Latency: request accepted at cen edge k → dout_valid high after cen edge k+2. It stays high until the next cen edge, which updates or clears it.
- dout_* are held unchanged while cen=0.
- Simultaneous requests from all N: each is granted exactly once within N consecutive cen edges, in pointer order.
- A requester holding req=1 after its ack is re-eligible only after the other pending requesters have been served.

## Configuration
- JT51_PHROM_ARB_FOLD_EN defined: quarter-wave folding as in Operation, using phase[9:8].
- Not defined: rom_addr = phase[7:0], dout_sign=0, phase[9:8] ignored (8-bit quarter-wave phase mode).

## Test plan
- Reset: drive rst_n=0 mid-stream with two results in flight → dout_valid=0 at once, no result appears after release, first grant goes to requester 0.
- Single request, FOLD_EN: req[1] with phase=0x100, cen=1 → ack[1] for one edge, rom_addr=0xFF, dout_id=1, dout_sign=0, dout_logsin=0x000 two edges later. Phase=0x000 → rom_addr=0x00, logsin=0x859.
- Sign path: phase=0x3FF → rom_addr=0x00, dout_sign=1, dout_logsin=0x859.
- Round robin: all N=4 requests held high → grants 0,1,2,3,0 on consecutive edges; dout_id sequence 0,1,2,3 starting two edges after the first grant.
- cen gating: cen toggling 1,0,1,0 with one request → ack only in cen=1 cycles, latency is exactly 2 cen edges, outputs hold while cen=0.
- FOLD_EN undefined: phase=0x3FF → rom_addr=0xFF, dout_sign=0, dout_logsin=0x000.
